mandelbrot_scan_ctrl: RTL

Frame scan controller that drives one `mandelbrot_calc` iteration engine. On `frame_start` it walks every pixel of an H_RES×V_RES frame in raster order. For each pixel it:
- generates the fixed-point c coordinate,
- issues a `start` to the engine and waits for its one-cycle done pulse,
- writes the resulting 8-bit value to the frame buffer through a ready/valid write port.

It sits between the host/config registers and the frame-buffer writer.

---
 rtl/mandelbrot_scan_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mandelbrot_scan_ctrl.sv
// mandelbrot_scan_ctrl: walks an H_RES x V_RES frame in raster order, issuing one
// mandelbrot_calc job per pixel and writing the 8-bit result to the frame buffer.
// Optional build macro MANDELBROT_INSIDE_BLACK_EN: pixels inside the set are written as 8'h00.
module mandelbrot_scan_ctrl #(
    parameter int unsigned WIDTH  = 27,
    parameter int unsigned FBITS  = 23,
    parameter int unsigned H_RES  = 640,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [WIDTH-1:0]  x_min,
    input  logic [WIDTH-1:0]  y_max,
    input  logic [WIDTH-1:0]  step,
    input  logic [7:0]        max_iter,
    output logic              calc_start,
    output logic [WIDTH-1:0]  calc_c_real,
    output logic [WIDTH-1:0]  calc_c_imag,
    output logic [7:0]        calc_max_iter,
    input  logic [7:0]        calc_iter_count,
    input  logic              calc_is_inside,
    input  logic              calc_is_done,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        ADVANCE
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   x_min_q;
    logic [WIDTH-1:0]   step_q;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [ADDR_W-1:0]  addr;
    logic               inside_q;

    logic last_col;
    logic last_row;
    assign last_col = (col == COL_W'(H_RES - 1));
    assign last_row = (row == ROW_W'(V_RES - 1));

    // inside flag is kept for debug visibility; fraction field is the engine's concern
    logic unused_ok;
    assign unused_ok = ^{inside_q, calc_c_real[FBITS-1:0]};

    // scan sequencer: per pixel ISSUE -> WAIT -> WRITE -> ADVANCE, all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            x_min_q       <= '0;
            step_q        <= '0;
            col           <= '0;
            row           <= '0;
            addr          <= '0;
            inside_q      <= 1'b0;
            calc_start    <= 1'b0;
            calc_c_real   <= '0;
            calc_c_imag   <= '0;
            calc_max_iter <= '0;
            wr_valid      <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            calc_start <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        x_min_q       <= x_min;
                        step_q        <= step;
                        calc_max_iter <= max_iter;
                        calc_c_real   <= x_min;
                        calc_c_imag   <= y_max;
                        col           <= '0;
                        row           <= '0;
                        addr          <= '0;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    calc_start <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (calc_is_done) begin
                        inside_q <= calc_is_inside;
`ifdef MANDELBROT_INSIDE_BLACK_EN
                        wr_data  <= calc_is_inside ? 8'h00 : calc_iter_count;
`else
                        wr_data  <= calc_iter_count;
`endif
                        wr_addr  <= addr;
                        wr_valid <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (last_col && last_row) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            state <= ADVANCE;
                        end
                    end
                end
                ADVANCE: begin
                    addr <= addr + ADDR_W'(1);
                    if (!last_col) begin
                        col         <= col + COL_W'(1);
                        calc_c_real <= calc_c_real + step_q;
                    end else begin
                        col         <= '0;
                        row         <= row + ROW_W'(1);
                        calc_c_real <= x_min_q;
                        calc_c_imag <= calc_c_imag - step_q;
                    end
                    state <= ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
